// File: rtl/score_pkg.sv
// score_pkg: shared glyph geometry, BCD digit type and score FSM states
package score_pkg;
  localparam int GLYPH_W = 16;
  localparam int GLYPH_H = 32;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, ADD, CARRY, ACK} score_state_t;
endpackage

// File: rtl/bcd_digit_inc.sv
// bcd_digit_inc: one BCD digit plus addend plus carry-in
//   d, addend : BCD inputs (0..9)
//   cin       : carry in
//   sum       : (d + addend + cin) mod 10
//   cout      : carry out (raw sum > 9)
module bcd_digit_inc
  import score_pkg::*;
(
  input  bcd_t d,
  input  bcd_t addend,
  input  logic cin,
  output bcd_t sum,
  output logic cout
);
  logic [4:0] raw;
  always_comb begin
    raw = 5'(d) + 5'(addend) + 5'(cin);
    cout = raw > 5'd9;
    sum = cout ? 4'(raw - 5'd10) : raw[3:0];
  end
endmodule

// File: rtl/score_display_ctrl.sv
// score_display_ctrl: BCD score keeper and per-pixel digit renderer for the glyph lookup
//   clk, reset              : clock, synchronous active-high reset
//   addReq/addValue/addAck  : add handshake (value clamped to 9), ack pulses on commit
//   clearReq                : zero score and overflow, abort any add
//   startOfFrame            : latches score into the display copy
//   pixelX, pixelY          : current pixel
//   digit, offsetX, offsetY : glyph lookup request, one cycle after the pixel
//   insideRectangle         : pixel hits a visible (unblanked, unblinked) digit cell
//   busy, overflow          : FSM not idle, sticky carry-out of the top digit
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int          DIGITS       = 4,
  parameter logic [10:0] ORIGIN_X     = 11'd16,
  parameter logic [10:0] ORIGIN_Y     = 11'd16,
  parameter int          BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        addReq,
  input  logic [3:0]  addValue,
  input  logic        clearReq,
  output logic        addAck,
  output logic        busy,
  output logic        overflow,
  output logic [3:0]  digit,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        insideRectangle
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int RW = IW + 4;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

  score_state_t state, state_nx;
  bcd_t [DIGITS-1:0] score, disp;
  bcd_t addend, inc_sum;
  logic [IW-1:0] idx, pos;
  logic inc_cout, at_top;
  logic [FW-1:0] frame_cnt;
  logic phase;
  logic [RW-1:0] rel_x;
  logic [4:0] rel_y;
  logic in_rect, acc, show;
  logic [DIGITS-1:0] lead;

  // ADD feeds the latched addend into digit 0; CARRY feeds +1 into digit idx
  bcd_digit_inc u_inc (
    .d     (score[idx]),
    .addend(state == ADD ? addend : 4'd0),
    .cin   (state == CARRY),
    .sum   (inc_sum),
    .cout  (inc_cout)
  );

  always_comb begin
    at_top = idx == IW'(DIGITS - 1);
    addAck = state == ACK;
    busy = state != IDLE;
    state_nx = IDLE;
    if (!clearReq)
      case (state)
        IDLE:    state_nx = addReq ? ADD : IDLE;
        ADD:     state_nx = inc_cout && DIGITS > 1 ? CARRY : ACK;
        CARRY:   state_nx = inc_cout && !at_top ? CARRY : ACK;
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      score <= '0;
      overflow <= 1'b0;
      addend <= '0;
      idx <= '0;
    end else begin
      state <= state_nx;
      if (clearReq) begin
        score <= '0;
        overflow <= 1'b0;
      end else begin
        if (state == IDLE && addReq) begin
          addend <= addValue > 4'd9 ? 4'd9 : addValue;
          idx <= '0;
        end
        if (state == ADD || state == CARRY) score[idx] <= inc_sum;
        if (state == ADD) idx <= IW'(1);
        if (state == CARRY && inc_cout && !at_top) idx <= idx + 1'b1;
        if (inc_cout && ((state == CARRY && at_top) || (state == ADD && DIGITS == 1))) overflow <= 1'b1;
      end
    end
  end

  // Tear-free: the renderer only ever sees the copy taken at frame start
  always_ff @(posedge clk) begin
    if (reset) disp <= '0;
    else if (startOfFrame) disp <= score;
  end

  always_ff @(posedge clk) begin
    if (reset || clearReq || !overflow) begin
      frame_cnt <= '0;
      phase <= 1'b0;
    end else if (startOfFrame) begin
      frame_cnt <= frame_cnt == FW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
      phase <= frame_cnt == FW'(BLINK_FRAMES - 1) ? ~phase : phase;
    end
  end

  always_comb begin
    rel_x = RW'(pixelX - ORIGIN_X);
    rel_y = 5'(pixelY - ORIGIN_Y);
    in_rect = pixelX >= ORIGIN_X && {1'b0, pixelX} < {1'b0, ORIGIN_X} + 12'(GLYPH_W * DIGITS) &&
              pixelY >= ORIGIN_Y && {1'b0, pixelY} < {1'b0, ORIGIN_Y} + 12'(GLYPH_H);
    // leftmost cell holds the most significant digit
    pos = IW'(DIGITS - 1) - rel_x[RW-1:4];
    // lead[i]: digit i or a more significant one is non-zero
    acc = 1'b0;
    lead = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc = acc || disp[i] != 4'd0;
      lead[i] = acc;
    end
    show = in_rect && (lead[pos] || pos == '0) && !phase;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= '0;
      offsetX <= '0;
      offsetY <= '0;
      insideRectangle <= 1'b0;
    end else begin
      digit <= disp[pos];
      offsetX <= {7'd0, rel_x[3:0]};
      offsetY <= {6'd0, rel_y};
      insideRectangle <= show;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// tb_score_display_ctrl: scoreboard bench with an integer-arithmetic score model
module tb_score_display_ctrl;
  localparam int DIGITS = 4;
  localparam int BF = 2;
  localparam int OX = 16;
  localparam int OY = 16;
  localparam int MOD = 10 ** DIGITS;

  logic clk = 1'b0, reset = 1'b1;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic startOfFrame = 1'b0, addReq = 1'b0, clearReq = 1'b0;
  logic [3:0] addValue = '0;
  logic addAck, busy, overflow, insideRectangle;
  logic [3:0] digit;
  logic [10:0] offsetX, offsetY;

  score_display_ctrl #(.DIGITS(DIGITS), .ORIGIN_X(11'(OX)), .ORIGIN_Y(11'(OY)), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
    .addReq(addReq), .addValue(addValue), .clearReq(clearReq), .addAck(addAck), .busy(busy),
    .overflow(overflow), .digit(digit), .offsetX(offsetX), .offsetY(offsetY),
    .insideRectangle(insideRectangle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;
  int m_score = 0, m_disp = 0, m_frames = 0;
  bit m_ovf = 0;

  typedef struct {int geo; int ins; int dig; int ox; int oy;} rexp_t;
  rexp_t r_q[$];
  int ack_q[$];
  logic probe_flag = 1'b0, rd_valid = 1'b0;

  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // carry steps needed after digit 0 when adding a to s
  function automatic int carries(int s, int a);
    int k;
    if (s % 10 + a < 10) return 0;
    k = 1;
    for (int p = 1; p < DIGITS - 1 && (s / (10 ** p)) % 10 == 9; p++) k++;
    return k;
  endfunction

  always @(negedge clk)
    if (!reset && addAck) begin
      if (ack_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack at cycle %0d", cyc);
      end else check("ack_cycle", cyc, ack_q.pop_front());
    end

  always @(posedge clk) rd_valid <= probe_flag;

  always @(negedge clk)
    if (rd_valid) begin
      rexp_t e;
      if (r_q.size() == 0) begin
        total++;
        $display("FAIL render_queue_empty at cycle %0d", cyc);
      end else begin
        e = r_q.pop_front();
        check("insideRectangle", int'(insideRectangle), e.ins);
        if (e.geo != 0) begin
          check("digit", int'(digit), e.dig);
          check("offsetX", int'(offsetX), e.ox);
          check("offsetY", int'(offsetY), e.oy);
        end
      end
    end

  task automatic add(int v);
    int a, t;
    a = v > 9 ? 9 : v;
    ack_q.push_back(cyc + 2 + carries(m_score, a));
    addValue = 4'(v);
    addReq = 1'b1;
    t = 0;
    @(negedge clk);
    while (!addAck && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!addAck) begin
      total++;
      $display("FAIL add_timeout: no addAck within 20 cycles (cycle %0d)", cyc);
    end
    @(posedge clk);
    #1 addReq = 1'b0;
    m_score += a;
    if (m_score >= MOD) begin
      m_score -= MOD;
      m_ovf = 1;
    end
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    m_disp = m_score;
    if (m_ovf) m_frames++;
    @(posedge clk);
    #1 startOfFrame = 1'b0;
  endtask

  task automatic clear();
    clearReq = 1'b1;
    m_score = 0;
    m_ovf = 0;
    m_frames = 0;
    @(posedge clk);
    #1 clearReq = 1'b0;
  endtask

  task automatic probe(int px, int py);
    rexp_t e;
    int pos, phase;
    phase = m_ovf ? (m_frames / BF) % 2 : 0;
    e.geo = int'(px >= OX && px < OX + 16 * DIGITS && py >= OY && py < OY + 32);
    e.ins = 0; e.dig = 0; e.ox = 0; e.oy = 0;
    if (e.geo != 0) begin
      pos = DIGITS - 1 - (px - OX) / 16;
      e.dig = (m_disp / (10 ** pos)) % 10;
      e.ins = int'((pos == 0 || m_disp >= 10 ** pos) && phase == 0);
      e.ox = (px - OX) % 16;
      e.oy = py - OY;
    end
    r_q.push_back(e);
    pixelX = 11'(px);
    pixelY = 11'(py);
    probe_flag = 1'b1;
    @(posedge clk);
    #1 probe_flag = 1'b0;
  endtask

  task automatic probe_cells(int row);
    for (int c = 0; c < DIGITS; c++) probe(OX + 16 * c + 3 * c, OY + row);
  endtask

  initial begin
    int n, r;
    repeat (3) @(posedge clk);
    #1;
    check("reset_addAck", int'(addAck), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_inside", int'(insideRectangle), 0);
    check("reset_digit", int'(digit), 0);
    check("reset_offsetX", int'(offsetX), 0);
    check("reset_offsetY", int'(offsetY), 0);
    reset = 1'b0;
    probe(OX + 48, OY + 5);
    probe_cells(7);
    add(7);
    add(5);
    probe_cells(2);
    frame();
    probe_cells(9);
    clear();
    frame();
    repeat (111) add(9);
    add(1);
    frame();
    probe_cells(0);
    probe_cells(31);
    clear();
    repeat (111) add(9);
    addValue = 4'd1;
    addReq = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("busy_in_carry", int'(busy), 1);
    clearReq = 1'b1;
    addReq = 1'b0;
    m_score = 0; m_ovf = 0; m_frames = 0;
    @(posedge clk);
    #1 clearReq = 1'b0;
    check("busy_after_clear", int'(busy), 0);
    check("overflow_after_clear", int'(overflow), 0);
    n = 0;
    repeat (8) @(negedge clk) if (addAck) n++;
    check("no_ack_after_clear", n, 0);
    @(posedge clk);
    #1 frame();
    probe_cells(4);
    repeat (1111) add(9);
    add(3);
    for (int f = 1; f <= 5; f++) begin
      frame();
      probe(OX + 50, OY + 10);
      probe(OX + 20, OY + 10);
    end
    clear();
    check("overflow_cleared", int'(overflow), 0);
    add(15);
    frame();
    probe(OX + 48, OY + 5);
    probe(OX - 1, OY + 5);
    probe(OX + 48, OY + 32);
    probe(OX + 63, OY + 31);
    probe(OX + 64, OY + 31);
    probe(OX + 50, OY - 1);
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) clear();
      else if (r < 9) add($urandom_range(0, 15));
      else if (r < 12) frame();
      else probe($urandom_range(OX - 4, OX + 16 * DIGITS + 4), $urandom_range(OY - 3, OY + 35));
    end
    repeat (4) @(posedge clk);
    check("ack_queue_drained", ack_q.size(), 0);
    check("render_queue_drained", r_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
